// File: rtl/alu_mc_if.sv
// Request/response bundle between the register-file read side and the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op_code;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;
    logic             err;

    modport master (
        output in_valid, op_code, a, b,
        input  in_ready, out_valid, result, result_hi, flags, err
    );

    modport slave (
        input  in_valid, op_code, a, b,
        output in_ready, out_valid, result, result_hi, flags, err
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: legacy ASM_* ops, carry-aware arithmetic, shifts/rotates,
// {V,N,Z,C} status register and a WIDTH-cycle shift-add multiplier.
//
// state     | meaning
// S_IDLE    | accepting requests; single-cycle ops complete on the accept edge
// S_MUL_RUN | shift-add iterations in progress, in_ready low
module alu_mc #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int M  = WIDTH - 1;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MUL_RUN = 1'b1;

    localparam logic [3:0] ASM_LDI  = 4'd0,  ASM_CLR  = 4'd1,  ASM_SER = 4'd2,  ASM_MOV  = 4'd3;
    localparam logic [3:0] ASM_ADD  = 4'd4,  ASM_ADDI = 4'd5,  ASM_INC = 4'd6,  ASM_DEC  = 4'd7;
    localparam logic [3:0] ASM_AND  = 4'd8,  ASM_ANDI = 4'd9,  ASM_OR  = 4'd10, ASM_ORI  = 4'd11;
    localparam logic [3:0] ASM_COM  = 4'd12, ASM_EOR  = 4'd13;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mul_a, acc_hi, acc_lo;
    logic [WIDTH-1:0] result_q, result_hi_q;
    logic [3:0]       flags_q;
    logic             out_valid_q, err_q;

    logic             c_in;
    logic [WIDTH-1:0] add_b, sub_b;
    logic             add_ci, sub_bi;
    logic [WIDTH:0]   sum, diff, mul_sum;
    logic             v_add, v_sub;
    logic [WIDTH-1:0] res, next_hi, next_lo;
    logic             c_new, v_new, legal, is_mul, is_cp;

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flags     = flags_q;
    assign bus.err       = err_q;

    assign c_in = flags_q[0];

    // Pick the second adder/subtractor operand and carry-in for the current op.
    always_comb begin
        add_b  = bus.b;
        add_ci = 1'b0;
        sub_b  = bus.b;
        sub_bi = 1'b0;
        if (!bus.op_code[4]) begin
            if (bus.op_code[3:0] == ASM_INC) add_b = WIDTH'(1);
            if (bus.op_code[3:0] == ASM_DEC) sub_b = WIDTH'(1);
        end else begin
            if (bus.op_code[3:0] == 4'd0) add_ci = c_in;
            if (bus.op_code[3:0] == 4'd2) sub_bi = c_in;
        end
    end

    assign sum   = {1'b0, bus.a} + {1'b0, add_b} + (WIDTH + 1)'(add_ci);
    assign diff  = {1'b0, bus.a} - {1'b0, sub_b} - (WIDTH + 1)'(sub_bi);
    assign v_add = (bus.a[M] == add_b[M]) && (sum[M] != bus.a[M]);
    assign v_sub = (bus.a[M] != sub_b[M]) && (diff[M] != bus.a[M]);

    // One shift-add step: conditionally add a into the high half, then shift right.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mul_a} : '0);
    assign next_hi = mul_sum[WIDTH:1];
    assign next_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Decode the op and form result plus carry/overflow for single-cycle ops.
    always_comb begin
        res    = '0;
        c_new  = c_in;
        v_new  = 1'b0;
        legal  = 1'b1;
        is_mul = 1'b0;
        is_cp  = 1'b0;
        if (!bus.op_code[4]) begin
            case (bus.op_code[3:0])
                ASM_LDI:                   res = bus.b;
                ASM_CLR:                   res = '0;
                ASM_SER:                   res = '1;
                ASM_MOV:                   res = bus.a;
                ASM_ADD, ASM_ADDI, ASM_INC: begin
                    res = sum[WIDTH-1:0]; c_new = sum[WIDTH]; v_new = v_add;
                end
                ASM_DEC: begin
                    res = diff[WIDTH-1:0]; c_new = diff[WIDTH]; v_new = v_sub;
                end
                ASM_AND, ASM_ANDI:         res = bus.a & bus.b;
                ASM_OR, ASM_ORI:           res = bus.a | bus.b;
                ASM_COM:                   res = ~bus.a;
                ASM_EOR:                   res = bus.a ^ bus.b;
                default:                   legal = 1'b0;
            endcase
        end else begin
            case (bus.op_code[3:0])
                4'd0: begin
                    res = sum[WIDTH-1:0]; c_new = sum[WIDTH]; v_new = v_add;
                end
                4'd1, 4'd2: begin
                    res = diff[WIDTH-1:0]; c_new = diff[WIDTH]; v_new = v_sub;
                end
                4'd3: begin
                    res = {bus.a[WIDTH-2:0], 1'b0}; c_new = bus.a[M]; v_new = res[M] ^ c_new;
                end
                4'd4: begin
                    res = {1'b0, bus.a[WIDTH-1:1]}; c_new = bus.a[0]; v_new = res[M] ^ c_new;
                end
                4'd5: begin
                    res = {bus.a[M], bus.a[WIDTH-1:1]}; c_new = bus.a[0]; v_new = res[M] ^ c_new;
                end
                4'd6: begin
                    res = {bus.a[WIDTH-2:0], c_in}; c_new = bus.a[M]; v_new = res[M] ^ c_new;
                end
                4'd7: begin
                    res = {c_in, bus.a[WIDTH-1:1]}; c_new = bus.a[0]; v_new = res[M] ^ c_new;
                end
                4'd8:    is_mul = 1'b1;
                4'd9: begin
                    res = diff[WIDTH-1:0]; c_new = diff[WIDTH]; v_new = v_sub; is_cp = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    // Control FSM, multiplier datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mul_a       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (is_mul) begin
                            state  <= S_MUL_RUN;
                            cnt    <= CW'(WIDTH);
                            mul_a  <= bus.a;
                            acc_hi <= '0;
                            acc_lo <= bus.b;
                        end else begin
                            out_valid_q <= 1'b1;
                            err_q       <= !legal;
                            result_hi_q <= '0;
                            if (!legal) begin
                                result_q <= '0;
                            end else begin
                                if (!is_cp) result_q <= res;
                                flags_q <= {v_new, res[M], (res == '0), c_new};
                            end
                        end
                    end
                end
                S_MUL_RUN: begin
                    acc_hi <= next_hi;
                    acc_lo <= next_lo;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b0;
                        result_q    <= next_lo;
                        result_hi_q <= next_hi;
                        flags_q     <= {1'b0, next_lo[M], (next_lo == '0), (next_hi != '0)};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=4 and WIDTH=8 with hand-computed results.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] sweep_exp [14];

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(4)) bus4 ();
    alu_mc_if #(.WIDTH(8)) bus8 ();

    alu_mc #(.WIDTH(4)) u_alu4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    alu_mc #(.WIDTH(8)) u_alu8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; returns one cycle later, after the accept edge.
    task automatic issue4(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b);
        bus4.in_valid = 1'b1;
        bus4.op_code  = op;
        bus4.a        = a;
        bus4.b        = b;
        @(negedge clk);
    endtask

    task automatic idle4();
        bus4.in_valid = 1'b0;
    endtask

    task automatic chk4(input string tag, input logic [3:0] res, input logic [3:0] flg);
        chk({tag, "_ov"}, 32'(bus4.out_valid), 32'd1);
        chk({tag, "_res"}, 32'(bus4.result), 32'(res));
        chk({tag, "_flags"}, 32'(bus4.flags), 32'(flg));
    endtask

    initial begin
        sweep_exp = '{4'h8, 4'h0, 4'hF, 4'h1, 4'h9, 4'h9, 4'h2,
                      4'h0, 4'h0, 4'h0, 4'h9, 4'h9, 4'hE, 4'h9};
        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.op_code = '0; bus4.a = '0; bus4.b = '0;
        bus8.in_valid = 1'b0; bus8.op_code = '0; bus8.a = '0; bus8.b = '0;
        repeat (2) @(negedge clk);

        chk("rst_res", 32'(bus4.result), 32'd0);
        chk("rst_hi", 32'(bus4.result_hi), 32'd0);
        chk("rst_flags", 32'(bus4.flags), 32'd0);
        chk("rst_ov", 32'(bus4.out_valid), 32'd0);
        chk("rst_err", 32'(bus4.err), 32'd0);
        chk("rst_rdy", 32'(bus4.in_ready), 32'd1);
        chk("rst_rdy8", 32'(bus8.in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Legacy sweep, back to back
        for (int i = 0; i < 14; i++) begin
            issue4(5'(i), 4'b0001, 4'b1000);
            chk($sformatf("sweep%0d_ov", i), 32'(bus4.out_valid), 32'd1);
            chk($sformatf("sweep%0d_res", i), 32'(bus4.result), 32'(sweep_exp[i]));
            chk($sformatf("sweep%0d_err", i), 32'(bus4.err), 32'd0);
        end
        idle4();
        chk("sweep_flags", 32'(bus4.flags), 32'h4);
        @(negedge clk);
        chk("ov_drop", 32'(bus4.out_valid), 32'd0);
        chk("ov_hold_res", 32'(bus4.result), 32'h9);

        // Flags
        issue4(5'b00100, 4'h7, 4'h1); idle4(); chk4("add_ovf", 4'h8, 4'b1100);
        issue4(5'b10001, 4'h3, 4'h5); idle4(); chk4("sub_brw", 4'hE, 4'b0101);
        issue4(5'b11001, 4'h5, 4'h5); idle4(); chk4("cp_eq", 4'hE, 4'b0010);
        chk("cp_hi", 32'(bus4.result_hi), 32'd0);

        // Carry chain and shifts
        issue4(5'b00100, 4'hF, 4'h1); idle4(); chk4("add_cy", 4'h0, 4'b0011);
        issue4(5'b10000, 4'h2, 4'h3); idle4(); chk4("adc", 4'h6, 4'b0000);
        issue4(5'b10111, 4'h2, 4'h0); idle4(); chk4("ror", 4'h1, 4'b0000);
        issue4(5'b10011, 4'h9, 4'h0); idle4(); chk4("lsl", 4'h2, 4'b1001);
        issue4(5'b10101, 4'h8, 4'h0); idle4(); chk4("asr", 4'hC, 4'b1100);
        issue4(5'b10110, 4'hA, 4'h0); idle4(); chk4("rol", 4'h4, 4'b1001);
        issue4(5'b10100, 4'h1, 4'h0); idle4(); chk4("lsr", 4'h0, 4'b1011);
        issue4(5'b00110, 4'hF, 4'h0); idle4(); chk4("inc_wrap", 4'h0, 4'b0011);
        issue4(5'b00111, 4'h0, 4'h0); idle4(); chk4("dec_wrap", 4'hF, 4'b0101);
        issue4(5'b10010, 4'h5, 4'h2); idle4(); chk4("sbc", 4'h2, 4'b0000);

        // MUL F x F with a follow-on request held during the run
        issue4(5'b11000, 4'hF, 4'hF);
        bus4.op_code = 5'b00100; bus4.a = 4'h2; bus4.b = 4'h3;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("mul_rdy_t%0d", k), 32'(bus4.in_ready), 32'd0);
            chk($sformatf("mul_ov_t%0d", k), 32'(bus4.out_valid), 32'd0);
            @(negedge clk);
        end
        chk4("mul", 4'h1, 4'b0001);
        chk("mul_hi", 32'(bus4.result_hi), 32'hE);
        chk("mul_rdy_t5", 32'(bus4.in_ready), 32'd1);
        chk("mul_err", 32'(bus4.err), 32'd0);
        @(negedge clk);
        idle4();
        chk4("post_mul_add", 4'h5, 4'b0000);
        chk("post_mul_hi", 32'(bus4.result_hi), 32'd0);

        // Illegal ops leave flags alone
        issue4(5'b10001, 4'h3, 4'h5); idle4(); chk4("sub_pre", 4'hE, 4'b0101);
        issue4(5'b11100, 4'h7, 4'h7); idle4(); chk4("ill_ext", 4'h0, 4'b0101);
        chk("ill_ext_err", 32'(bus4.err), 32'd1);
        chk("ill_ext_hi", 32'(bus4.result_hi), 32'd0);
        issue4(5'b01110, 4'h7, 4'h7); idle4(); chk4("ill_leg", 4'h0, 4'b0101);
        chk("ill_leg_err", 32'(bus4.err), 32'd1);
        issue4(5'b00011, 4'h3, 4'h0); idle4(); chk4("mov_after_ill", 4'h3, 4'b0001);
        chk("mov_err", 32'(bus4.err), 32'd0);

        // Reset while a MUL is running
        issue4(5'b11000, 4'h3, 4'h3);
        idle4();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmul_res", 32'(bus4.result), 32'd0);
        chk("rmul_flags", 32'(bus4.flags), 32'd0);
        chk("rmul_hi", 32'(bus4.result_hi), 32'd0);
        chk("rmul_ov", 32'(bus4.out_valid), 32'd0);
        chk("rmul_rdy", 32'(bus4.in_ready), 32'd1);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rmul_no_ov%0d", k), 32'(bus4.out_valid), 32'd0);
        end
        issue4(5'b00100, 4'h2, 4'h2); idle4(); chk4("post_rst_add", 4'h4, 4'b0000);

        // WIDTH=8 multiply
        bus8.in_valid = 1'b1; bus8.op_code = 5'b11000; bus8.a = 8'hFF; bus8.b = 8'hFF;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("mul8_ov_t%0d", k), 32'(bus8.out_valid), 32'd0);
            chk($sformatf("mul8_rdy_t%0d", k), 32'(bus8.in_ready), 32'd0);
            @(negedge clk);
        end
        chk("mul8_ov", 32'(bus8.out_valid), 32'd1);
        chk("mul8_res", 32'(bus8.result), 32'h01);
        chk("mul8_hi", 32'(bus8.result_hi), 32'hFE);
        chk("mul8_flags", 32'(bus8.flags), 32'b0001);
        chk("mul8_rdy", 32'(bus8.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised successor to the CPU's 4-bit ALU. Keeps the 14 legacy `ASM_*` operations and adds carry-aware arithmetic, shifts/rotates, a status-flag register and an iterative multiplier.
- Operands enter through a valid/ready handshake. Results are registered and flagged with a one-cycle `out_valid` pulse.
- Sits between the register file and the writeback stage of the next-generation datapath.

Parameters:
- `WIDTH`, default 4: operand/result width in bits; legal range 4..32. Replaces the fixed `CAP` width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request this cycle.
- `op_code`  in  5  bit 4 = 0: legacy `ASM_*` code in [3:0]; bit 4 = 1: extended op in [3:0].
- `a`  in  WIDTH  operand A (destination register value).
- `b`  in  WIDTH  operand B (source register or immediate).
- `out_valid`  out  1  one-cycle pulse: result/flags updated.
- `result`  out  WIDTH  registered result.
- `result_hi`  out  WIDTH  upper half of MUL product; 0 for every other op.
- `flags`  out  4  registered status flags {V,N,Z,C}, bits [3:0] = {V,N,Z,C}.
- `err`  out  1  accompanies `out_valid` when `op_code` was illegal.

Behaviour:
- Reset (`rst_n` = 0 at a clk edge): `result`, `result_hi`, `flags`, `err` and `out_valid` all 0; `in_ready` = 1; state = IDLE. Reset dominates every other input, including a MUL in progress, which is aborted with no `out_valid`.
- Accept: `in_valid & in_ready` at an edge. Operands and `op_code` are captured.
- Single-cycle ops: `out_valid` = 1 in the cycle after accept. `in_ready` stays 1, so throughput is one op per cycle, back to back.
- No output backpressure: `result` holds its value until the next `out_valid`.
- Legacy ops, in bit-exact agreement with the existing ALU:
  - LDI = b; CLR = 0; SER = all-ones; MOV = a
  - ADD / ADDI = a + b
  - INC = a + 1; DEC = a − 1
  - AND / ANDI = a & b; OR / ORI = a | b; COM = ~a; EOR = a ^ b
  - All arithmetic is modulo 2^WIDTH.
- Extended ops (op_code[3:0]):
  - 0 ADC: a + b + C
  - 1 SUB: a − b
  - 2 SBC: a − b − C
  - 3 LSL; 4 LSR; 5 ASR (one bit, on a)
  - 6 ROL; 7 ROR (one bit, through C)
  - 8 MUL: unsigned a × b; low half → `result`, high half → `result_hi`
  - 9 CP: a − b, flags only, `result` unchanged
  - 10..15: illegal.
- Flags:
  - Z and N (N = result MSB) are updated by every legal op, including CLR/SER/LDI/MOV. For CP they are computed from the internal difference.
  - C:
    - ADD/ADDI/ADC: carry out.
    - SUB/SBC/CP/DEC: borrow (1 when the unsigned a < subtrahend).
    - INC: carry out.
    - Shifts/rotates: the bit shifted out.
    - MUL: 1 iff `result_hi` ≠ 0.
    - Logic, LDI/CLR/SER/MOV: C unchanged.
  - V: two's-complement overflow for add/sub-class ops; cleared by logic ops and MUL; for shifts/rotates V = N ^ C.
- MUL state machine: IDLE → MUL_RUN → IDLE.
  - MUL_RUN runs WIDTH shift-add iterations, one per cycle, with a count register of width clog2(WIDTH+1).
  - `in_ready` = 0 throughout MUL_RUN; `in_valid` is ignored there.
  - `out_valid` is asserted exactly WIDTH+1 cycles after accept. `in_ready` returns to 1 in that same cycle, so a new op may be accepted in the `out_valid` cycle.
- Illegal op: `out_valid` = 1 and `err` = 1 in the next cycle; `result` = 0; `result_hi` = 0; `flags` unchanged.
- `err` = 0 on every legal `out_valid`.
- `in_ready` depends only on state, never combinationally on `in_valid`.

Test Plan (WIDTH = 4 unless stated):
- Legacy sweep: a = 4'b0001, b = 4'b1000, all 14 `ASM_*` codes back to back. Results: 8, 0, F, 1, 9, 9, 2, 0, 0, 0, 9, 9, E, 9 on consecutive `out_valid` pulses, one per cycle.
- Flags: ADD 7 + 1 → `result` = 8, flags V=1 N=1 Z=0 C=0. Then SUB 3 − 5 → E, C=1, N=1, V=0. Then CP 5, 5 → Z=1, `result` still E.
- Carry chain: ADD F + 1 → 0, Z=1, C=1. Then ADC 2 + 3 → 6. Then ROR a = 4'b0010 with C=0 → 4'b0001, C=0.
- MUL: F × F accepted at cycle t → `out_valid` at t+5, `result` = 1, `result_hi` = E, C=1. `in_ready` = 0 for cycles t+1..t+4. An `in_valid` held high during the run is accepted at t+5.
- Reset mid-MUL: drop `rst_n` at t+2 → next edge: all outputs 0, `in_ready` = 1, no `out_valid` for the aborted op. Repeat at WIDTH = 8: 0xFF × 0xFF → `result` 0x01, `result_hi` 0xFE, `out_valid` at t+9.
- Illegal: `op_code` 5'b11100 → `out_valid` = 1, `err` = 1, `result` = 0, flags unchanged from the prior op.
